// File: rtl/count_sequence_checker.sv
// Monitor for the 3-bit mode-switchable counter: predicts each sample from the previous one,
// locks after LOCK_N consecutive matches, then reports mismatches (ERR) and completed laps (LAP).
module count_sequence_checker #(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned ERR_W  = 8,
  parameter int unsigned LAP_W  = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [2:0]       i_count,
  input  logic             i_m,
  output logic             o_locked,
  output logic             o_err,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic             o_lap,
  output logic [LAP_W-1:0] o_lap_cnt
);

  typedef enum logic [1:0] {StSeek, StAcquire, StLocked} state_e;

  state_e           r_state, w_state_next;
  logic [2:0]       r_prev_c;
  logic             r_prev_m;
  logic [3:0]       r_match_cnt;
  logic             r_locked, r_err, r_lap;
  logic [ERR_W-1:0] r_err_cnt;
  logic [LAP_W-1:0] r_lap_cnt;

  logic [2:0] w_expected;
  logic       w_match, w_lock_hit, w_err_d, w_lap_d;
  logic [3:0] w_match_inc;

  always_comb begin
    w_expected = 3'd0;
    if (!r_prev_m) begin
      w_expected = r_prev_c + 3'd1;
    end else begin
      unique case (r_prev_c)
        3'd0:    w_expected = 3'd1;
        3'd1:    w_expected = 3'd3;
        3'd2:    w_expected = 3'd6;
        3'd3:    w_expected = 3'd2;
        3'd4:    w_expected = 3'd0;
        3'd5:    w_expected = 3'd4;
        3'd6:    w_expected = 3'd7;
        default: w_expected = 3'd5;
      endcase
    end
  end

  assign w_match     = (i_count == w_expected);
  assign w_match_inc = r_match_cnt + 4'd1;
  assign w_lock_hit  = (w_match_inc == 4'(LOCK_N));

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= StSeek;
    else         r_state <= w_state_next;
  end

  // Next-state logic; EN low always falls back to SEEK
  always_comb begin
    w_state_next = r_state;
    if (!i_en) begin
      w_state_next = StSeek;
    end else begin
      unique case (r_state)
        StSeek:    w_state_next = StAcquire;
        StAcquire: if (w_match && w_lock_hit) w_state_next = StLocked;
        StLocked:  if (!w_match) w_state_next = StAcquire;
        default:   w_state_next = StSeek;
      endcase
    end
  end

  // Output decode, registered below
  always_comb begin
    w_err_d = 1'b0;
    w_lap_d = 1'b0;
    if (i_en && (r_state == StLocked)) begin
      w_err_d = !w_match;
      w_lap_d = w_match && (i_count == 3'd0);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_prev_c    <= 3'd0;
      r_prev_m    <= 1'b0;
      r_match_cnt <= 4'd0;
    end else if (i_en) begin
      r_prev_c <= i_count;
      r_prev_m <= i_m;
      if (r_state == StSeek || !w_match) r_match_cnt <= 4'd0;
      else if (r_state == StAcquire)     r_match_cnt <= w_match_inc;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_lap     <= 1'b0;
      r_err_cnt <= '0;
      r_lap_cnt <= '0;
    end else begin
      r_locked <= (w_state_next == StLocked);
      r_err    <= w_err_d;
      r_lap    <= w_lap_d;
      if (w_err_d && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_W'(1);
      if (w_lap_d) r_lap_cnt <= r_lap_cnt + LAP_W'(1);
    end
  end

  assign o_locked  = r_locked;
  assign o_err     = r_err;
  assign o_lap     = r_lap;
  assign o_err_cnt = r_err_cnt;
  assign o_lap_cnt = r_lap_cnt;

endmodule

// File: doc/count_sequence_checker.md
# count_sequence_checker

Downstream monitor for the 3-bit mode-switchable counter. Each clock it samples the counter's COUNT and mode input M, predicts the next count from the counter's fixed transition table, and flags deviations. It locks after a run of correct transitions, then reports errors and completed laps through pulses and counters. Used as an on-chip self-check and as the reference model in counter benches.

## Interface
- LOCK_N, 4: consecutive correct transitions required to enter LOCKED; legal range 1..15.
- ERR_W, 8: width of ERR_CNT.
- LAP_W, 8: width of LAP_CNT.
- CLOCK  in  1  sole clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- EN  in  1  sample-valid qualifier; low means the counter is held in reset or untrusted.
- COUNT  in  3  counter output, sampled every edge while EN=1.
- M  in  1  counter mode, sampled on the same edge as COUNT.
- LOCKED  out  1  high while state is LOCKED.
- ERR  out  1  one-cycle pulse on a mismatch detected in LOCKED.
- ERR_CNT  out  ERR_W  saturating count of ERR pulses.
- LAP  out  1  one-cycle pulse when a matched transition lands on COUNT=0 in LOCKED.
- LAP_CNT  out  LAP_W  wrapping count of LAP pulses.

## Operation
- Transition table, written as next(c,m):
  - m=0: 0→1, 1→2, 2→3, 3→4, 4→5, 5→6, 6→7, 7→0.
  - m=1: 0→1, 1→3, 2→6, 3→2, 4→0, 5→4, 6→7, 7→5.
- Registers: prev_c[2:0], prev_m, match_cnt[3:0], state.
- Sample k has expected value next(prev_c, prev_m). A match means COUNT_k equals that value.
- States:
  - SEEK: at the first edge with EN=1, capture COUNT and M into prev_c and prev_m, clear match_cnt, and go to ACQUIRE.
  - ACQUIRE, on each EN=1 edge:
    - Match: match_cnt+1. When the new value equals LOCK_N, go to LOCKED.
    - Mismatch: clear match_cnt and stay. No ERR.
  - LOCKED, on each EN=1 edge:
    - Match: stay. If COUNT_k=0, pulse LAP and increment LAP_CNT, wrapping.
    - Mismatch: pulse ERR, increment ERR_CNT (saturating at all-ones), clear match_cnt, go to ACQUIRE.
- In ACQUIRE and LOCKED, prev_c and prev_m load COUNT_k and M_k every EN=1 edge, matched or not.
- EN=0 at any edge returns to SEEK from any state. ERR and LAP are 0 that cycle; ERR_CNT and LAP_CNT hold.
- A mode change between samples is legal: the expectation always uses the previous sample's M.
- Reset, including mid-operation:
  - state goes to SEEK.
  - prev_c, prev_m, match_cnt, ERR_CNT and LAP_CNT go to 0.
  - LOCKED, ERR and LAP go to 0.

## Timing
- All outputs are registered. ERR and LAP are high for exactly the one cycle after the edge that captured the offending or lap sample.
- LOCKED rises on the edge that captures the LOCK_N-th consecutive match.
  - Minimum from the first EN=1 edge is LOCK_N+1 edges.
  - LOCKED falls on the same edge that raises ERR.
- Back-to-back mismatches in LOCKED produce a single ERR, because the first mismatch leaves LOCKED.
- ERR_CNT and LAP_CNT update on the same edge as their pulse, so the new values are visible while the pulse is high.
- Saturation: with ERR_CNT at 2^ERR_W−1, a further mismatch still pulses ERR and the count holds.
- Lap wrap: with LAP_CNT at 2^LAP_W−1, a further LAP sets LAP_CNT to 0.

## Test plan
- Binary lock (defaults): Reset, then EN=1, M=0, COUNT 0,1,2,3,4.
  - LOCKED rises on the 5th sample's edge, ERR=0.
  - Continue through 5,6,7,0: one LAP pulse, LAP_CNT=1.
- Mode-switch lap: locked, with samples 0→1 under M=1 then 3,2,6,7,5,4,0 under M=1.
  - No ERR.
  - LAP pulses on 0, LAP_CNT increments by 1.
  - Switching to M=0 on sample 3 so the next sample is 4 also produces no ERR.
- Injected fault: locked at prev_c=2, prev_m=0, then COUNT=5.
  - ERR pulses 1 cycle, ERR_CNT=1, LOCKED=0, state ACQUIRE.
  - Relocks after 4 further correct samples.
- EN drop: locked, then EN=0 for 1 cycle, then the sequence restarts at 0.
  - State SEEK, then ACQUIRE. No ERR, counters held, relock after LOCK_N+1 samples.
- Saturation and wrap: ERR_W=2, LAP_W=2.
  - Force 5 lock/fault cycles: ERR_CNT ends at 3.
  - Run 5 laps: LAP_CNT ends at 1.
- Async reset mid-LOCKED: assert Reset between edges.
  - All outputs go to 0 immediately, without waiting for a CLOCK edge.
  - After release the block stays in SEEK until EN=1.
